// File: rtl/frame_writer_rgb888_pkg.sv
// Shared constants and FSM encoding for the frame write-back path.
package frame_writer_rgb888_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } fw_state_e;

  localparam int DATA_W_DEF     = 24;
  localparam int ADDR_W_DEF     = 17;
  localparam int FRAME_WIDTH    = 480;
  localparam int FRAME_HEIGHT   = 272;
  localparam int FIFO_DEPTH_DEF = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clogb(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/px_sync_fifo.sv
// Small synchronous pixel FIFO; head is visible combinationally.
module px_sync_fifo import frame_writer_rgb888_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iPush,
  input  logic                     iPop,
  input  logic [DATA_W-1:0]        iData,
  output logic [DATA_W-1:0]        oHead,
  output logic                     oFull,
  output logic                     oEmpty,
  output logic [clogb(DEPTH):0]    oCount
);

  localparam int AW = clogb(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [AW:0]       count;

  // Pointers and occupancy; callers never push when full without popping.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (iPush) wrPtr <= wrPtr + 1'b1;
      if (iPop)  rdPtr <= rdPtr + 1'b1;
      case ({iPush, iPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge iClk) begin
    if (iPush) mem[wrPtr] <= iData;
  end

  assign oHead  = mem[rdPtr];
  assign oFull  = (count == (AW+1)'(DEPTH));
  assign oEmpty = (count == '0);
  assign oCount = count;

endmodule

// File: rtl/frame_writer_rgb888.sv
// Frame write-back: FIFO-buffered pixel stream to raster-ordered BRAM writes.
module frame_writer_rgb888 import frame_writer_rgb888_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WIDTH      = FRAME_WIDTH,
  parameter int HEIGHT     = FRAME_HEIGHT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEn,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iBaseAddr,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iPixel,
  input  logic              iWrReady,
  output logic              oCs,
  output logic              oWe,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy,
  output logic              oFrameDone,
  output logic              oOverflow
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = clogb(NPIX);
  localparam int COL_W = clogb(WIDTH);
  localparam int ROW_W = clogb(HEIGHT);
  localparam int FAW   = clogb(FIFO_DEPTH);

  fw_state_e         state, stateNxt;
  logic [ADDR_W-1:0] baseAddr;
  logic [CNT_W-1:0]  pixCnt, wrIdx;
  logic [COL_W-1:0]  colCnt;
  logic [ROW_W-1:0]  rowCnt;
  logic              weReg;

  logic              fifoFull, fifoEmpty;
  logic [FAW:0]      fifoCount;
  logic [DATA_W-1:0] fifoHead;

  logic pixIn, push, pop, drop, lastPix, startHit;

  assign pop      = iEn && !fifoEmpty && iWrReady;
  assign pixIn    = iEn && (state == ST_ACTIVE) && iValid;
  assign push     = pixIn && (!fifoFull || pop);
  assign drop     = pixIn && fifoFull && !pop;
  assign lastPix  = (pixCnt == CNT_W'(NPIX - 1));
  assign startHit = iEn && (state == ST_IDLE) && iStart;

  px_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) uFifo (
    .iClk   (iClk),
    .iRst   (iRst),
    .iPush  (push),
    .iPop   (pop),
    .iData  (iPixel),
    .oHead  (fifoHead),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty),
    .oCount (fifoCount)
  );

  // State register; frozen while disabled.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)    state <= ST_IDLE;
    else if (iEn) state <= stateNxt;
  end

  // Next state: FLUSH ends once the FIFO drains (including on the final pop).
  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_IDLE:   if (iStart) stateNxt = ST_ACTIVE;
      ST_ACTIVE: if (iValid && lastPix) stateNxt = ST_FLUSH;
      ST_FLUSH:  if (fifoEmpty || (pop && fifoCount == (FAW+1)'(1))) stateNxt = ST_DONE;
      ST_DONE:   stateNxt = ST_IDLE;
      default:   stateNxt = ST_IDLE;
    endcase
  end

  // Status decode; write strobes are masked while disabled so a held
  // write is presented exactly once, when the enable returns.
  always_comb begin
    oBusy      = (state == ST_ACTIVE) || (state == ST_FLUSH);
    oFrameDone = (state == ST_DONE) && iEn;
    oCs        = weReg && iEn;
    oWe        = weReg && iEn;
  end

  // Frame counters, overflow flag and the registered BRAM port.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      baseAddr  <= '0;
      pixCnt    <= '0;
      wrIdx     <= '0;
      colCnt    <= '0;
      rowCnt    <= '0;
      oOverflow <= 1'b0;
      weReg     <= 1'b0;
      oAddr     <= '0;
      oData     <= '0;
    end else if (iEn) begin
      weReg <= pop;
      if (startHit) begin
        baseAddr  <= iBaseAddr;
        pixCnt    <= '0;
        wrIdx     <= '0;
        colCnt    <= '0;
        rowCnt    <= '0;
        oOverflow <= 1'b0;
      end
      // Dropped pixels still count so the frame ends on schedule.
      if (pixIn && !lastPix) pixCnt <= pixCnt + 1'b1;
      if (drop) oOverflow <= 1'b1;
      if (pop) begin
        oAddr <= baseAddr + ADDR_W'(wrIdx);
        oData <= fifoHead;
        wrIdx <= wrIdx + 1'b1;
        if (colCnt == COL_W'(WIDTH - 1)) begin
          colCnt <= '0;
          rowCnt <= (rowCnt == ROW_W'(HEIGHT - 1)) ? '0 : rowCnt + 1'b1;
        end else begin
          colCnt <= colCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_writer_rgb888.sv
// Directed bench: table of frame scenarios plus reset / idle sequences.
module tb_frame_writer_rgb888;

  localparam int DW = 24;
  localparam int AW = 17;
  localparam int NP = 12;

  logic          iClk = 1'b0;
  logic          iRst = 1'b0;
  logic          iEn = 1'b0, iStart = 1'b0, iValid = 1'b0, iWrReady = 1'b0;
  logic [AW-1:0] iBaseAddr = '0;
  logic [DW-1:0] iPixel = '0;
  logic          oCs, oWe, oBusy, oFrameDone, oOverflow;
  logic [AW-1:0] oAddr;
  logic [DW-1:0] oData;

  frame_writer_rgb888 #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(4), .HEIGHT(3), .FIFO_DEPTH(4)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iStart(iStart), .iBaseAddr(iBaseAddr),
    .iValid(iValid), .iPixel(iPixel), .iWrReady(iWrReady),
    .oCs(oCs), .oWe(oWe), .oAddr(oAddr), .oData(oData),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit rec = 1'b0;

  int            wrCyc[$];
  logic [AW-1:0] wrAddr[$];
  logic [DW-1:0] wrData[$];
  int            doneCnt = 0;
  int            doneCyc = -1;

  typedef struct {
    logic [AW-1:0] base;
    int stallFrom, stallLen;   // iWrReady low window
    int gapFrom, gapLen;       // iValid low window
    int enFrom, enLen;         // iEn low window
    int expWrites;
    bit expOvf;
    int dropIdx;               // -1: no pixel lost
    int expFirst, expLast;     // cycles relative to first pixel cycle
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int k);
    return {8'(f), 8'(k), 8'hC3 ^ 8'(k)};
  endfunction

  always @(posedge iClk) cyc <= cyc + 1;

  // Capture the write port; writes must never be visible while disabled.
  always @(negedge iClk) begin
    if (iRst && rec) begin
      if (oWe) begin
        wrCyc.push_back(cyc - t0);
        wrAddr.push_back(oAddr);
        wrData.push_back(oData);
      end
      if (oFrameDone) begin
        doneCnt++;
        doneCyc = cyc - t0;
      end
    end
    if (iRst && !iEn) begin
      checks++;
      if (oWe || oCs) begin
        failures++;
        $display("FAIL we_while_disabled: oWe=%0b oCs=%0b expected 0", oWe, oCs);
      end
    end
  end

  task automatic run_frame(input vec_t v, input int f);
    int k;
    int n;
    int src;
    bit adv;
    wrCyc.delete(); wrAddr.delete(); wrData.delete();
    doneCnt = 0; doneCyc = -1;
    @(posedge iClk); #1;
    iEn = 1'b1; iStart = 1'b1; iBaseAddr = v.base; iValid = 1'b0; iWrReady = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    t0 = cyc; rec = 1'b1; k = 0;
    for (int t = 0; t < 60; t++) begin
      iEn      = !(t >= v.enFrom && t < v.enFrom + v.enLen);
      iWrReady = !(t >= v.stallFrom && t < v.stallFrom + v.stallLen);
      iValid   = (k < NP) && !(t >= v.gapFrom && t < v.gapFrom + v.gapLen);
      iPixel   = pix(f, k);
      // A stray start with another base mid-frame must be ignored.
      iStart    = (t == 6);
      iBaseAddr = (t == 6) ? 17'h0AAAA : v.base;
      adv = iEn && iValid;
      @(posedge iClk); #1;
      if (adv) k++;
      if (doneCnt > 0) break;
    end
    iStart = 1'b0; iValid = 1'b0; iEn = 1'b1; iWrReady = 1'b1; iBaseAddr = v.base;
    repeat (3) @(posedge iClk);
    #1;
    rec = 1'b0;
    chk($sformatf("f%0d_done_count", f), doneCnt, 1);
    chk($sformatf("f%0d_writes", f), wrCyc.size(), v.expWrites);
    chk($sformatf("f%0d_overflow", f), oOverflow, v.expOvf);
    chk($sformatf("f%0d_busy_after", f), oBusy, 0);
    n = (wrCyc.size() < v.expWrites) ? wrCyc.size() : v.expWrites;
    if (n > 0) begin
      chk($sformatf("f%0d_first_cycle", f), wrCyc[0], v.expFirst);
      chk($sformatf("f%0d_last_cycle", f), wrCyc[n-1], v.expLast);
      chk($sformatf("f%0d_done_cycle", f), doneCyc, v.expLast);
    end
    for (int j = 0; j < n; j++) begin
      src = (v.dropIdx >= 0 && j >= v.dropIdx) ? j + 1 : j;
      chk($sformatf("f%0d_addr%0d", f, j), wrAddr[j], AW'(v.base + AW'(j)));
      chk($sformatf("f%0d_data%0d", f, j), wrData[j], pix(f, src));
    end
  endtask

  initial begin
    //            base      stall  gap   en    wr  ovf drop first last
    vecs[0] = '{17'h00100, 0, 0, 0, 0, 0, 0, 12, 1'b0, -1, 2, 13};  // back-to-back
    vecs[1] = '{17'h00100, 1, 4, 4, 1, 0, 0, 12, 1'b0, -1, 6, 17};  // stall, FIFO fills
    vecs[2] = '{17'h00100, 1, 4, 0, 0, 0, 0, 11, 1'b1,  4, 6, 16};  // 5th pixel dropped
    vecs[3] = '{17'h00100, 0, 0, 0, 0, 5, 3, 12, 1'b0, -1, 2, 16};  // enable low 3 cycles
    vecs[4] = '{17'h1FFF8, 0, 0, 0, 0, 0, 0, 12, 1'b0, -1, 2, 13};  // address wrap

    iRst = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_we", oWe, 0);
    chk("rst_cs", oCs, 0);
    chk("rst_addr", oAddr, 0);
    chk("rst_data", oData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oFrameDone, 0);
    chk("rst_ovf", oOverflow, 0);
    iRst = 1'b1; iEn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], i);
      if (i == 2) chk("ovf_sticky_idle", oOverflow, 1);
    end

    // Async reset mid-frame: outputs clear without waiting for a clock.
    @(posedge iClk); #1;
    iStart = 1'b1; iBaseAddr = 17'h00100; iWrReady = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    for (int t = 0; t < 5; t++) begin
      iValid = 1'b1; iPixel = pix(9, t);
      @(posedge iClk); #1;
    end
    #1;
    chk("pre_rst_we", oWe, 1);
    chk("pre_rst_busy", oBusy, 1);
    iRst = 1'b0;
    #1;
    chk("async_rst_we", oWe, 0);
    chk("async_rst_cs", oCs, 0);
    chk("async_rst_busy", oBusy, 0);
    chk("async_rst_addr", oAddr, 0);
    iValid = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b1;

    // Pixels offered in IDLE must be ignored.
    wrCyc.delete(); t0 = cyc; rec = 1'b1;
    iValid = 1'b1; iPixel = 24'h123456;
    repeat (4) @(posedge iClk);
    #1;
    iValid = 1'b0; rec = 1'b0;
    chk("idle_no_writes", wrCyc.size(), 0);
    chk("idle_not_busy", oBusy, 0);

    run_frame(vecs[0], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
